// File: rtl/divider_pkg.sv
// Shared types and constants for the divider sequencing controller.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TRIAL,
    STEP,
    FINISH,
    DONE,
    ERROR
  } state_t;

  localparam int MAX_ITER_DEFAULT = 256;
  localparam int WDOG_WIDTH       = 9;

  typedef struct packed {
    logic load_a;
    logic load_b;
    logic load_m;
    logic load_result;
    logic enable_op1;
    logic enable_op2;
    logic enable_sub;
    logic enable_zero;
    logic increment;
  } strobe_t;

endpackage

// File: rtl/divider_control_if.sv
// Host/datapath handshake bundle seen by the divider controller.
interface divider_control_if;

  logic Start;
  logic ScanEnable;
  logic nBorrow;
  logic Overflow;
  logic Ready;
  logic Done;
  logic Error;
  logic LoadA;
  logic LoadB;
  logic LoadM;
  logic LoadResult;
  logic EnableOp1;
  logic EnableOp2;
  logic EnableSub;
  logic EnableZero;
  logic Increment;
  logic Test;

  modport slave (
    input  Start, ScanEnable, nBorrow, Overflow,
    output Ready, Done, Error, LoadA, LoadB, LoadM, LoadResult,
           EnableOp1, EnableOp2, EnableSub, EnableZero, Increment, Test
  );

  modport master (
    output Start, ScanEnable, nBorrow, Overflow,
    input  Ready, Done, Error, LoadA, LoadB, LoadM, LoadResult,
           EnableOp1, EnableOp2, EnableSub, EnableZero, Increment, Test
  );

endinterface

// File: rtl/divider_iter_counter.sv
// Watchdog counter for subtract steps; terminal flags that the next enabled
// step reaches LIMIT.
module divider_iter_counter
  import divider_pkg::*;
#(
  parameter int WIDTH = WDOG_WIDTH,
  parameter int LIMIT = MAX_ITER_DEFAULT
) (
  input  logic Clock,
  input  logic nReset,
  input  logic clear,
  input  logic enable,
  input  logic freeze,
  output logic terminal
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      count_reg <= '0;
    end else if (freeze) begin
      count_reg <= count_reg;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign terminal = (count_reg >= WIDTH'(LIMIT - 1));

endmodule

// File: rtl/divider_control.sv
// Sequencing FSM for the bit-slice divider: repeated subtraction with a
// quotient counter, overflow/watchdog error exit and scan freeze.
module divider_control
  import divider_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEFAULT
) (
  input  logic              Clock,
  input  logic              nReset,
  divider_control_if.slave  bus
);

  state_t  state_reg;
  state_t  state_next;
  logic    error_reg;
  logic    wdog_terminal;
  strobe_t strobe;
  logic    ready;
  logic    done;

  divider_iter_counter #(
    .WIDTH (WDOG_WIDTH),
    .LIMIT (MAX_ITER)
  ) u_wdog (
    .Clock    (Clock),
    .nReset   (nReset),
    .clear    (state_reg == LOAD),
    .enable   (state_reg == STEP),
    .freeze   (bus.ScanEnable),
    .terminal (wdog_terminal)
  );

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_reg <= IDLE;
      error_reg <= 1'b0;
    end else if (!bus.ScanEnable) begin
      state_reg <= state_next;
      if (state_reg == IDLE && state_next == LOAD) begin
        error_reg <= 1'b0;
      end else if (state_next == ERROR) begin
        error_reg <= 1'b1;
      end
    end
  end

  // Strobes depend only on state_reg (and the scan gate); nBorrow/Overflow
  // steer state_next alone.
  always_comb begin
    state_next = state_reg;
    strobe     = '0;
    ready      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (bus.Start) state_next = LOAD;
      end
      LOAD: begin
        strobe.enable_op1  = 1'b1;
        strobe.load_a      = 1'b1;
        strobe.enable_op2  = 1'b1;
        strobe.load_b      = 1'b1;
        strobe.enable_zero = 1'b1;
        strobe.load_m      = 1'b1;
        state_next         = TRIAL;
      end
      TRIAL: begin
        strobe.enable_sub = 1'b1;
        state_next        = bus.nBorrow ? STEP : FINISH;
      end
      STEP: begin
        strobe.enable_sub = 1'b1;
        strobe.load_a     = 1'b1;
        strobe.increment  = 1'b1;
        state_next        = (bus.Overflow || wdog_terminal) ? ERROR : TRIAL;
      end
      FINISH: begin
        strobe.load_result = 1'b1;
        state_next         = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERROR: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.ScanEnable) begin
      strobe = '0;
      done   = 1'b0;
    end
  end

  assign bus.Ready      = ready;
  assign bus.Done       = done;
  assign bus.Error      = error_reg;
  assign bus.LoadA      = strobe.load_a;
  assign bus.LoadB      = strobe.load_b;
  assign bus.LoadM      = strobe.load_m;
  assign bus.LoadResult = strobe.load_result;
  assign bus.EnableOp1  = strobe.enable_op1;
  assign bus.EnableOp2  = strobe.enable_op2;
  assign bus.EnableSub  = strobe.enable_sub;
  assign bus.EnableZero = strobe.enable_zero;
  assign bus.Increment  = strobe.increment;
  assign bus.Test       = bus.ScanEnable;

endmodule

// File: tb/tb_divider_control.sv
// Scoreboard bench: a small datapath plant around the controller, expected
// results from integer division pushed at issue time, popped on each Done.
module tb_divider_control;

  logic Clock = 1'b0;
  logic nReset = 1'b0;
  always #5 Clock = ~Clock;

  divider_control_if bus();

  divider_control dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  // Datapath plant driven by the strobes.
  logic [7:0] op1 = 8'd0, op2 = 8'd0;
  logic [7:0] a_reg = 8'd0, b_reg = 8'd0, m_reg = 8'd0;
  logic [7:0] q_reg = 8'd0, r_reg = 8'd0;

  always @(posedge Clock) begin
    if (bus.LoadA) a_reg <= bus.EnableOp1 ? op1 : (bus.EnableSub ? a_reg - b_reg : a_reg);
    if (bus.LoadB && bus.EnableOp2) b_reg <= op2;
    if (bus.LoadM && bus.EnableZero) m_reg <= 8'd0;
    else if (bus.Increment) m_reg <= m_reg + 8'd1;
    if (bus.LoadResult) begin
      q_reg <= m_reg;
      r_reg <= a_reg;
    end
  end

  assign bus.nBorrow  = (a_reg >= b_reg);
  assign bus.Overflow = bus.Increment && (m_reg == 8'hFF);

  logic [8:0] strobes;
  assign strobes = {bus.LoadA, bus.LoadB, bus.LoadM, bus.LoadResult, bus.EnableOp1,
                    bus.EnableOp2, bus.EnableSub, bus.EnableZero, bus.Increment};

  typedef struct {
    int a;
    int b;
    int latency;
    int q;
    int r;
    int err;
    int incs;
    int lres;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int done_count = 0;
  int last_q = 0;
  int last_r = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: integer division; a zero divisor exhausts 256 steps and errors.
  task automatic push_expect(input int a, input int b, input int extra);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.err = 1;
      e.q = last_q;
      e.r = last_r;
      e.incs = 256;
      e.lres = 0;
      e.latency = 1 + 2 * 256 + 1 + extra;
    end else begin
      e.err = 0;
      e.q = a / b;
      e.r = a % b;
      e.incs = e.q;
      e.lres = 1;
      e.latency = 2 * e.q + 4 + extra;
      last_q = e.q;
      last_r = e.r;
    end
    sbq.push_back(e);
  endtask

  // Monitor: detects accepted starts, counts strobes, checks at Done.
  bit busy = 1'b0;
  int cyc = 0, incs = 0, lres = 0;

  always @(negedge Clock) begin
    if (!nReset) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        cyc++;
        incs += int'(bus.Increment);
        lres += int'(bus.LoadResult);
      end
      if (bus.Done) begin
        if (!busy || sbq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          $display("div %0d/%0d: lat=%0d q=%0d r=%0d err=%0b incs=%0d",
                   e.a, e.b, cyc, q_reg, r_reg, bus.Error, incs);
          check("latency", cyc, e.latency);
          check("quotient", int'(q_reg), e.q);
          check("remainder", int'(r_reg), e.r);
          check("error", int'(bus.Error), e.err);
          check("increments", incs, e.incs);
          check("load_result", lres, e.lres);
        end
        busy = 1'b0;
        done_count++;
      end
      if (!busy && bus.Ready && bus.Start && !bus.ScanEnable) begin
        busy = 1'b1;
        cyc = 0;
        incs = 0;
        lres = 0;
      end
    end
  end

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic issue(input int a, input int b, input bit push, input int extra);
    @(posedge Clock);
    #2;
    op1 = 8'(a);
    op2 = 8'(b);
    bus.Start = 1'b1;
    if (push) push_expect(a, b, extra);
    @(posedge Clock);
    #2;
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int start_count;
    start_count = done_count;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge Clock);
      if (done_count != start_count) return;
    end
    check("done_timeout", 0, 1);
    finish_run();
  endtask

  task automatic run(input int a, input int b);
    issue(a, b, 1'b1, 0);
    wait_done(1000);
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.ScanEnable = 1'b0;

    // Reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_ready", int'(bus.Ready), 1);
    check("rst_done", int'(bus.Done), 0);
    check("rst_error", int'(bus.Error), 0);
    check("rst_strobes", int'(strobes), 0);
    check("rst_test", int'(bus.Test), 0);
    @(posedge Clock);
    #2 nReset = 1'b1;

    // Directed cases
    run(100, 7);
    run(5, 9);
    run(255, 1);
    run(42, 0);
    @(negedge Clock);
    check("error_sticky", int'(bus.Error), 1);
    issue(77, 8, 1'b1, 0);
    @(negedge Clock);
    check("error_cleared", int'(bus.Error), 0);
    wait_done(1000);

    // Reset asserted across the end of a STEP cycle
    issue(100, 7, 1'b0, 0);
    repeat (6) @(negedge Clock);
    for (int i = 0; i < 10; i++) begin
      if (bus.EnableSub && !bus.LoadA) break;
      @(negedge Clock);
    end
    @(posedge Clock);
    #2 nReset = 1'b0;
    @(negedge Clock);
    check("rst_during_step", int'(bus.Increment), 1);
    @(posedge Clock);
    #2 nReset = 1'b1;
    @(negedge Clock);
    check("midrst_ready", int'(bus.Ready), 1);
    check("midrst_strobes", int'(strobes), 0);
    check("midrst_done", int'(bus.Done), 0);
    run(100, 7);

    // Scan freeze for 10 cycles inside the loop
    issue(200, 3, 1'b1, 10);
    repeat (20) @(negedge Clock);
    @(posedge Clock);
    #2 bus.ScanEnable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("scan_strobes", int'(strobes), 0);
      check("scan_test", int'(bus.Test), 1);
      check("scan_done", int'(bus.Done), 0);
    end
    @(posedge Clock);
    #2 bus.ScanEnable = 1'b0;
    wait_done(1000);

    // Start held through DONE: second division begins from the next IDLE
    @(posedge Clock);
    #2;
    op1 = 8'd9;
    op2 = 8'd4;
    bus.Start = 1'b1;
    push_expect(9, 4, 0);
    push_expect(9, 4, 0);
    wait_done(1000);
    @(posedge Clock);
    @(posedge Clock);
    #2 bus.Start = 1'b0;
    wait_done(1000);

    // Randomized divisions
    for (int i = 0; i < 12; i++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      if (i == 5) b = 0;
      else if (i % 3 == 0) b = int'($urandom_range(1, 8));
      else b = int'($urandom_range(1, 255));
      run(a, b);
    end

    repeat (4) @(negedge Clock);
    check("scoreboard_empty", sbq.size(), 0);
    finish_run();
  end

endmodule
